// File: rtl/bcd_counter_n_if.sv
// Bundle of count-control and status signals for bcd_counter_n.
// master drives en/up/load/din and observes q/tc/wrap/load_err;
// slave is the counter side.
`timescale 1ns/1ps
interface bcd_counter_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output en, up, load, din,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, din,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: cascadable DIGITS-wide packed-BCD up/down counter with
// synchronous load and enable, combinational terminal count, and
// registered wrap / load_err pulses.
// Build option: define BCD_COUNTER_SATURATE_EN to saturate at 99..9 / 00..0
// instead of wrapping modulo 10^DIGITS.
`timescale 1ns/1ps
module bcd_counter_n #(
  parameter int unsigned DIGITS = 4
) (
  input  logic            clk,
  input  logic            clr,
  bcd_counter_n_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] din_w;
  logic [W-1:0] din_clean;
  logic         din_bad;
  logic [W-1:0] q_inc, q_dec;
  logic         carry_out, borrow_out;

  assign din_w = bus.din;

  // Load value with illegal digits (>9) forced to zero, and the error flag
  always_comb begin
    din_clean = '0;
    din_bad   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (din_w[4*i +: 4] > 4'd9) begin
        din_bad = 1'b1;
      end else begin
        din_clean[4*i +: 4] = din_w[4*i +: 4];
      end
    end
  end

  // Increment ripple: a carry survives to the top only if every digit was 9
  always_comb begin
    logic carry;
    q_inc = q_q;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          q_inc[4*i +: 4] = '0;
        end else begin
          q_inc[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    carry_out = carry;
  end

  // Decrement ripple: a borrow survives to the top only if every digit was 0
  always_comb begin
    logic borrow;
    q_dec  = q_q;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          q_dec[4*i +: 4] = 4'd9;
        end else begin
          q_dec[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
    borrow_out = borrow;
  end

  // Next state: load beats enable beats hold; pulses default low
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      q_d        = din_clean;
      load_err_d = din_bad;
    end else if (bus.en) begin
      if (bus.up) begin
`ifdef BCD_COUNTER_SATURATE_EN
        q_d = carry_out ? q_q : q_inc;
`else
        q_d = q_inc;
`endif
        wrap_d = carry_out;
      end else begin
`ifdef BCD_COUNTER_SATURATE_EN
        q_d = borrow_out ? q_q : q_dec;
`else
        q_d = q_dec;
`endif
        wrap_d = borrow_out;
      end
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // tc reuses the ripple end-conditions: carry_out means all 9s,
  // borrow_out means all 0s
  assign bus.tc       = bus.en & (bus.up ? carry_out : borrow_out);
  assign bus.q        = q_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: a 3-digit instance plus a cascaded
// pair of 1-digit instances. The driver pushes expected responses; monitors
// pop and compare on the falling clock edge or on an asynchronous clear.
`timescale 1ns/1ps
module tb_bcd_counter_n;

  localparam int unsigned ND = 3;
`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int unsigned K_TC    = 0;
  localparam int unsigned K_ST    = 1;
  localparam int unsigned K_ASYNC = 2;
  localparam int unsigned K_CAS   = 3;

  typedef struct {
    int unsigned tag;
    int unsigned kind;
    logic [11:0] q;
    logic        wrap;
    logic        err;
    logic        tc;
    logic [7:0]  cq;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_counter_n_if #(.DIGITS(ND)) m ();
  bcd_counter_n_if #(.DIGITS(1))  c_lo ();
  bcd_counter_n_if #(.DIGITS(1))  c_hi ();

  bcd_counter_n #(.DIGITS(ND)) dut  (.clk(clk), .clr(clr), .bus(m.slave));
  bcd_counter_n #(.DIGITS(1))  u_lo (.clk(clk), .clr(clr), .bus(c_lo.slave));
  bcd_counter_n #(.DIGITS(1))  u_hi (.clk(clk), .clr(clr), .bus(c_hi.slave));

  assign c_hi.en   = c_lo.tc;
  assign c_hi.up   = c_lo.up;
  assign c_hi.load = 1'b0;
  assign c_hi.din  = 4'h0;

  function automatic logic [11:0] bcd3(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void push(input int unsigned kind, input int unsigned tag,
                               input string nm, input logic [11:0] xq,
                               input logic xw, input logic xe, input logic xtc,
                               input logic [7:0] xcq);
    exp_t e;
    e.tag = tag; e.kind = kind; e.q = xq; e.wrap = xw; e.err = xe;
    e.tc = xtc; e.cq = xcq; e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic check(input exp_t e);
    checks++;
    case (e.kind)
      K_TC: if (m.tc !== e.tc) begin
        errors++;
        $display("FAIL %s tc: got %b expected %b (t=%0t)", e.name, m.tc, e.tc, $time);
      end
      K_CAS: if ({c_hi.q, c_lo.q} !== e.cq) begin
        errors++;
        $display("FAIL %s cascade: got %h expected %h (t=%0t)", e.name, {c_hi.q, c_lo.q}, e.cq, $time);
      end
      default: if (m.q !== e.q || m.wrap !== e.wrap || m.load_err !== e.err) begin
        errors++;
        $display("FAIL %s state: got q=%h wrap=%b load_err=%b expected q=%h wrap=%b load_err=%b (t=%0t)",
                 e.name, m.q, m.wrap, m.load_err, e.q, e.wrap, e.err, $time);
      end
    endcase
  endtask

  // Clocked monitor: compare every entry due in this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].kind != K_ASYNC && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.tag < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale: checked at cycle %0d expected cycle %0d", e.name, cyc, e.tag);
      end else begin
        check(e);
      end
    end
  end

  // Asynchronous-clear monitor: compare just after clr falls, between edges
  always @(negedge clr) begin
    #1;
    while (sb.size() > 0 && sb[0].kind == K_ASYNC) begin
      check(sb.pop_front());
    end
  end

  // Digit invariant on every sampled cycle
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      for (int unsigned i = 0; i < ND; i++) begin
        logic [11:0] qv;
        qv = m.q;
        checks++;
        assert (qv[4*i +: 4] <= 4'd9)
          else begin
            errors++;
            $display("FAIL digit_range: got digit%0d=%h expected <=9", i, qv[4*i +: 4]);
          end
      end
    end
  end

  task automatic step(input string nm, input logic e, input logic u, input logic l,
                      input logic [11:0] d, input logic xtc, input logic [11:0] xq,
                      input logic xw, input logic xe);
    m.en = e; m.up = u; m.load = l; m.din = d;
    push(K_TC, cyc, nm, '0, 1'b0, 1'b0, xtc, '0);
    push(K_ST, cyc + 1, nm, xq, xw, xe, 1'b0, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0;
    m.en = 1'b0; m.up = 1'b1; m.load = 1'b0; m.din = '0;
    c_lo.en = 1'b0; c_lo.up = 1'b1; c_lo.load = 1'b0; c_lo.din = '0;
    #40;
    @(posedge clk); #1;
    push(K_ST, cyc, "reset", 12'h000, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    clr = 1'b1;

    for (int unsigned i = 1; i <= 10; i++)
      step("count_up", 1, 1, 0, 12'h000, 0, bcd3(i), 0, 0);

    step("load998", 1, 1, 1, 12'h998, 0, 12'h998, 0, 0);
    step("to999",   1, 1, 0, 12'h000, 0, 12'h999, 0, 0);
    step("wrap_up", 1, 1, 0, 12'h000, 1, SAT ? 12'h999 : 12'h000, 1, 0);
    step("post_wrap", 1, 1, 0, 12'h000, SAT, SAT ? 12'h999 : 12'h001, SAT, 0);

    step("load100", 1, 0, 1, 12'h100, 0, 12'h100, 0, 0);
    step("borrow",  1, 0, 0, 12'h000, 0, 12'h099, 0, 0);
    step("down098", 1, 0, 0, 12'h000, 0, 12'h098, 0, 0);
    step("load000", 1, 0, 1, 12'h000, 0, 12'h000, 0, 0);
    step("wrap_dn", 1, 0, 0, 12'h000, 1, SAT ? 12'h000 : 12'h999, 1, 0);
    step("hold",    0, 0, 0, 12'h000, 0, SAT ? 12'h000 : 12'h999, 0, 0);
    step("dir_up",  1, 1, 0, 12'h000, !SAT, SAT ? 12'h001 : 12'h000, !SAT, 0);
    step("dir_dn",  1, 0, 0, 12'h000, !SAT, SAT ? 12'h000 : 12'h999, !SAT, 0);

    step("load500", 0, 0, 1, 12'h500, 0, 12'h500, 0, 0);
    step("bad1A5",  1, 1, 1, 12'h1A5, 0, 12'h105, 0, 1);
    step("err_drop", 0, 1, 0, 12'h000, 0, 12'h105, 0, 0);
    step("badFFF",  0, 1, 1, 12'hFFF, 0, 12'h000, 0, 1);
    step("bad9A9",  0, 1, 1, 12'h9A9, 0, 12'h909, 0, 1);
    step("err_drop2", 0, 0, 0, 12'h000, 0, 12'h909, 0, 0);
    step("to910",   1, 1, 0, 12'h000, 0, 12'h910, 0, 0);

    // clear between edges while counting
    @(negedge clk); #2;
    push(K_ASYNC, cyc, "async_clr", 12'h000, 1'b0, 1'b0, 1'b0, '0);
    clr = 1'b0;
    @(posedge clk); #1;
    push(K_ST, cyc, "clr_held", 12'h000, 1'b0, 1'b0, 1'b0, '0);
    clr = 1'b1;
    step("resume1", 1, 1, 0, 12'h000, 0, 12'h001, 0, 0);
    step("resume2", 1, 1, 0, 12'h000, 0, 12'h002, 0, 0);
    step("idle",    0, 1, 0, 12'h000, 0, 12'h002, 0, 0);
    m.en = 1'b0;

    // cascade of two single-digit counters
    c_lo.en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    push(K_CAS, cyc, "cascade10", '0, 1'b0, 1'b0, 1'b0, SAT ? 8'h19 : 8'h10);
    repeat (15) @(posedge clk);
    #1;
    push(K_CAS, cyc, "cascade25", '0, 1'b0, 1'b0, 1'b0, SAT ? 8'h99 : 8'h25);
    c_lo.en = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
